// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch sequencer: datapath width, NOP encoding,
// word-alignment mask, FSM state encoding and the decode-facing output bundle.
package pc_seq_pkg;
  localparam int              XLEN       = 32;
  localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} fetch_state_e;

  // Everything decode sees alongside if_valid.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_out_t;
endpackage

// File: rtl/pc_incrementer.sv
// Combinational PC + 4 (modulo 2^XLEN).
//   pc_i        current PC
//   pc_plus4_o  pc_i + 4, wraps 32'hFFFF_FFFC -> 32'h0
module pc_incrementer
  import pc_seq_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_plus4_o
);
  assign pc_plus4_o = pc_i + 32'd4;
endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC owner and instruction-fetch sequencer between imem and decode.
//   clk/reset_n                      clock, async active-low reset
//   redirect_valid/redirect_target   taken branch/jump from execute
//   trap_valid/trap_vector           trap entry (wins over redirect)
//   imem_req/imem_addr               fetch request, held until imem_ack
//   imem_ack/imem_rdata              fetch completion and instruction word
//   if_valid/if_instr/if_pc/
//   if_pc_plus4/if_ready             one-entry valid/ready output to decode
//   misalign_err                     pulse after a misaligned redirect target
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  input  logic            if_ready,
  output logic            misalign_err
);
  localparam if_out_t OUT_RST = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pending_q, pending_d;
  if_out_t         out_q, out_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;

  logic            redir;
  logic [XLEN-1:0] new_pc;
  logic [XLEN-1:0] pc_plus4;

  pc_incrementer u_inc (.pc_i(pc_q), .pc_plus4_o(pc_plus4));

  assign redir  = trap_valid | redirect_valid;
  assign new_pc = (trap_valid ? trap_vector : redirect_target) & ALIGN_MASK;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    out_d     = out_q;
    valid_d   = valid_q;
    // Trap vectors are silently aligned; only branch targets report.
    mis_d     = redirect_valid & ~trap_valid & (|redirect_target[1:0]);
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redir) pc_d = new_pc;
      end
      FETCH: begin
        if (redir) begin
          // A live request is never withdrawn; park the target and drain it.
          if (imem_ack) pc_d = new_pc;
          else begin
            pending_d = new_pc;
            state_d   = DRAIN;
          end
        end else if (imem_ack) begin
          out_d   = '{instr: imem_rdata, pc: pc_q, pc_plus4: pc_plus4};
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redir) begin
          pc_d    = new_pc;
          state_d = FETCH;
        end else if (if_ready) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (redir) pending_d = new_pc;
        if (imem_ack) begin
          // Stale response dropped; latest redirect wins.
          pc_d    = redir ? new_pc : pending_q;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
    // Flush: anything handshaked this cycle was already taken by decode.
    if (redir) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VECTOR;
      pending_q <= '0;
      out_q     <= OUT_RST;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      mis_q     <= mis_d;
    end
  end

  // Request side depends on registered state only.
  assign imem_req     = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr    = pc_q;
  assign if_valid     = valid_q;
  assign if_instr     = out_q.instr;
  assign if_pc        = out_q.pc;
  assign if_pc_plus4  = out_q.pc_plus4;
  assign misalign_err = mis_q;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomized bench for pc_fetch_sequencer. A transaction-level model predicts
// fetch addresses, request timing, delivered instructions and misalign pulses;
// delivered instructions go into a scoreboard queue that a separate monitor
// checks against the decode-side outputs.
module tb_pc_fetch_sequencer;
  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] AMSK = 32'hFFFF_FFFC;

  logic        clk = 1'b0, reset_n = 1'b1;
  logic        redirect_valid = 1'b0, trap_valid = 1'b0;
  logic [31:0] redirect_target = '0, trap_vector = '0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        if_valid, if_ready = 1'b0, misalign_err;
  logic [31:0] if_instr, if_pc, if_pc_plus4;

  pc_fetch_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .reset_n(reset_n),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_ready(if_ready),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, n_deliv = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  typedef struct packed {logic [31:0] instr; logic [31:0] pc;} exp_t;
  exp_t sb[$];

  // Monitor: every cycle decode must see exactly the oldest undelivered word.
  always @(negedge clk) begin
    if (reset_n) begin
      if (sb.size() != 0) begin
        chk("if_valid", 32'(if_valid), 32'd1);
        chk("if_instr", if_instr, sb[0].instr);
        chk("if_pc", if_pc, sb[0].pc);
        chk("if_pc_plus4", if_pc_plus4, sb[0].pc + 32'd4);
        if (if_ready) begin
          void'(sb.pop_front());
          n_deliv++;
        end
      end else chk("if_valid_idle", 32'(if_valid), 32'd0);
    end
  end

  // Reference model: a fetch goes out whenever nothing is held for decode
  // (except the idle cycle after reset). A redirect seen while a request is
  // outstanding kills its response; the next request targets the latest
  // redirect, otherwise the word after the last delivered one.
  bit          boot, held, kill, exp_mis, prev_req, prev_ack;
  bit          m_redir, m_req, m_ack;
  logic [31:0] exp_addr, cur_addr, m_new;

  always @(negedge clk) begin
    #1;
    if (!reset_n) begin
      sb.delete();
      boot = 1; held = 0; kill = 0; exp_mis = 0; prev_req = 0; prev_ack = 0;
      exp_addr = RV; cur_addr = RV;
    end else begin
      chk("misalign_err", 32'(misalign_err), 32'(exp_mis));
      exp_mis = redirect_valid && !trap_valid && (redirect_target[1:0] != 2'b00);
      m_req = !boot && !held;
      chk("imem_req", 32'(imem_req), 32'(m_req));
      boot = 0;
      m_redir = trap_valid || redirect_valid;
      m_new   = (trap_valid ? trap_vector : redirect_target) & AMSK;
      if (m_req) begin
        if (!prev_req || prev_ack) begin
          cur_addr = exp_addr;
          kill     = 0;
        end
        chk("imem_addr", imem_addr, cur_addr);
      end
      if (m_redir) begin
        sb.delete();
        exp_addr = m_new;
        if (m_req) kill = 1;
      end
      m_ack = m_req && imem_ack;
      if (m_ack && !kill) begin
        sb.push_back('{instr: imem_rdata, pc: cur_addr});
        exp_addr = cur_addr + 32'd4;
      end
      prev_req = m_req;
      prev_ack = m_ack;
      held     = (sb.size() != 0);
    end
  end

  // imem responder: acks after ack_lat waiting cycles of a live request.
  int ack_lat = 0, wait_cnt = 0;

  task automatic step(input bit rv, input logic [31:0] rt, input bit tv,
                      input logic [31:0] tvec, input bit rdy);
    @(posedge clk); #1;
    redirect_valid  = rv;  redirect_target = rt;
    trap_valid      = tv;  trap_vector     = tvec;
    if_ready        = rdy;
    imem_rdata      = $urandom;
    if (imem_req && wait_cnt >= ack_lat) begin
      imem_ack = 1'b1;
      wait_cnt = 0;
    end else begin
      imem_ack = 1'b0;
      if (imem_req) wait_cnt++;
      else wait_cnt = 0;
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(1'b0, 32'h0, 1'b0, 32'h0, rdy);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !imem_req; i++) idle(1, 1'b1);
    chk("wait_req", 32'(imem_req), 32'd1);
  endtask

  // Asynchronous reset mid-cycle; outputs must drop immediately.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    redirect_valid = 1'b0; trap_valid = 1'b0; imem_ack = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, RV);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, NOP);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_pc_plus4", if_pc_plus4, 32'h0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    wait_cnt = 0;
  endtask

  initial begin
    logic [31:0] rt, tvec;
    bit          rv, tv, rdy;
    do_reset();
    // Back-to-back fetch from reset vector, immediate acks.
    ack_lat = 0;
    idle(12, 1'b1);
    // Decode stall while an instruction is held.
    idle(7, 1'b0);
    idle(3, 1'b1);
    // Redirect while the ack is delayed.
    ack_lat = 3;
    wait_req();
    step(1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    idle(10, 1'b1);
    // Trap beats redirect.
    ack_lat = 1;
    step(1'b1, 32'h300, 1'b1, 32'h200, 1'b1);
    idle(6, 1'b1);
    // Misaligned target.
    step(1'b1, 32'h102, 1'b0, 32'h0, 1'b1);
    idle(6, 1'b1);
    // PC wrap.
    ack_lat = 0;
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
    idle(6, 1'b1);
    // Reset while draining a killed request.
    ack_lat = 4;
    wait_req();
    step(1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
    idle(1, 1'b1);
    do_reset();
    ack_lat = 0;
    idle(8, 1'b1);
    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) ack_lat = $urandom_range(0, 3);
      rv   = ($urandom_range(0, 7) == 0);
      tv   = ($urandom_range(0, 15) == 0);
      rt   = $urandom;
      if ($urandom_range(0, 1) == 1) rt[1:0] = 2'b00;
      tvec = $urandom;
      rdy  = ($urandom_range(0, 3) != 0);
      step(rv, rt, tv, tvec, rdy);
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    idle(4, 1'b1);
    chk("delivered_enough", 32'(n_deliv > 100), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
